// File: rtl/pwm_mc.sv
// pwm_mc: multi-channel PWM generator.
// One shared prescaler and period counter drive CH duty comparators. Supports
// edge-aligned and center-aligned counting. Duty and mode are shadowed and only
// taken over at period boundaries, polarity applies immediately, and a one-clock
// strobe marks the start of each period.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           run enable; 0 holds counters at 0 and drives outputs inactive
//   dvsr         prescaler divisor; one count tick every dvsr+1 clocks
//   mode         0 = edge-aligned, 1 = center-aligned
//   duty         packed per-channel duty, channel i at [i*(n+1) +: n+1]
//   pol          per-channel polarity; 1 inverts the channel output
//   pwm          registered PWM outputs
//   period_start one-clock pulse when a new period begins
module pwm_mc #(
  parameter int unsigned n  = 8,
  parameter int unsigned CH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [31:0]         dvsr,
  input  logic                mode,
  input  logic [CH*(n+1)-1:0] duty,
  input  logic [CH-1:0]       pol,
  output logic [CH-1:0]       pwm,
  output logic                period_start
);

  localparam int unsigned DW = n + 1;
  localparam logic [n-1:0] CNT_MAX = {n{1'b1}};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [31:0]      q_q, q_d;
  logic [n-1:0]     cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             mode_act_q, mode_act_d;
  logic [CH*DW-1:0] duty_act_q, duty_act_d;
  logic [CH-1:0]    pwm_q, pwm_d;
  logic             ps_q, ps_d;

  logic             tick;
  logic             boundary;
  logic [CH-1:0]    raw;

  // Prescaler tick; a q beyond dvsr simply wraps through 2^32-1.
  assign tick = en && (q_q == dvsr);

  // Period end: top of the count in edge mode, bottom of the down ramp in center mode.
  assign boundary = tick && (mode_act_q ? ((cnt_q == '0) && (dir_q == DIR_DOWN))
                                        : (cnt_q == CNT_MAX));

  // Unsigned (n+1)-bit compare; duty >= 2^n therefore stays high for the whole period.
  always_comb begin
    raw = '0;
    for (int i = 0; i < CH; i++) begin
      raw[i] = ({1'b0, cnt_q} < duty_act_q[i*DW +: DW]);
    end
  end

  // Next-state for prescaler, counter, shadow registers and outputs.
  always_comb begin
    q_d        = q_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    mode_act_d = mode_act_q;
    duty_act_d = duty_act_q;
    pwm_d      = pwm_q;
    ps_d       = 1'b0;

    if (!en) begin
      // Idle: counters parked, shadows transparent so enabling starts with live values.
      q_d        = '0;
      cnt_d      = '0;
      dir_d      = DIR_UP;
      mode_act_d = mode;
      duty_act_d = duty;
      pwm_d      = pol;
    end else begin
      q_d   = tick ? 32'd0 : q_q + 32'd1;
      pwm_d = raw ^ pol;

      if (tick) begin
        if (!mode_act_q) begin
          cnt_d = cnt_q + n'(1);
        end else if (dir_q == DIR_UP) begin
          // Turnaround ticks hold the count so the extremes are counted twice.
          if (cnt_q == CNT_MAX) dir_d = DIR_DOWN;
          else                  cnt_d = cnt_q + n'(1);
        end else begin
          if (cnt_q == '0) dir_d = DIR_UP;
          else             cnt_d = cnt_q - n'(1);
        end
      end

      if (boundary) begin
        duty_act_d = duty;
        mode_act_d = mode;
        ps_d       = 1'b1;
        if (mode != mode_act_q) begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      mode_act_q <= 1'b0;
      duty_act_q <= '0;
      pwm_q      <= '0;
      ps_q       <= 1'b0;
    end else begin
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      mode_act_q <= mode_act_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
    end
  end

  assign pwm          = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_mc.sv
// tb_pwm_mc: scoreboard bench for pwm_mc. A phase-based reference model pushes the
// expected outputs every clock; they are popped and compared on the falling edge.
// Period-level measurements check high times and period lengths against constants.
module tb_pwm_mc;

  localparam int unsigned n  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned DW = n + 1;

  logic                clk;
  logic                rst;
  logic                en;
  logic [31:0]         dvsr;
  logic                mode;
  logic [CH*DW-1:0]    duty;
  logic [CH-1:0]       pol;
  logic [CH-1:0]       pwm;
  logic                period_start;

  pwm_mc #(.n(n), .CH(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .dvsr         (dvsr),
    .mode         (mode),
    .duty         (duty),
    .pol          (pol),
    .pwm          (pwm),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH*DW-1:0] pk(input int d0, input int d1, input int d2, input int d3);
    logic [CH*DW-1:0] v;
    v = '0;
    v[0*DW +: DW] = DW'(d0);
    v[1*DW +: DW] = DW'(d1);
    v[2*DW +: DW] = DW'(d2);
    v[3*DW +: DW] = DW'(d3);
    return v;
  endfunction

  // Reference model: position p inside the period, mapped to a count value.
  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          ps;
  } exp_t;

  exp_t          sb_q[$];
  int unsigned   m_q;
  int            m_p;
  logic          m_mode;
  int            m_duty[CH];
  logic [CH-1:0] m_pwm;
  logic          m_ps;
  int            m_c;
  int            m_len;

  function automatic int cnt_of(input int p, input logic md);
    if (!md) return p;
    return (p < (1 << n)) ? p : (1 << (n + 1)) - 1 - p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q = 0; m_p = 0; m_mode = 1'b0; m_pwm = '0; m_ps = 1'b0;
      for (int i = 0; i < CH; i++) m_duty[i] = 0;
    end else if (!en) begin
      m_q = 0; m_p = 0; m_mode = mode; m_pwm = pol; m_ps = 1'b0;
      for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i*DW +: DW]);
    end else begin
      m_c = cnt_of(m_p, m_mode);
      for (int i = 0; i < CH; i++) m_pwm[i] = (m_c < m_duty[i]) ^ pol[i];
      m_ps = 1'b0;
      if (m_q == dvsr) begin
        m_q   = 0;
        m_len = m_mode ? (1 << (n + 1)) : (1 << n);
        if (m_p == m_len - 1) begin
          m_p    = 0;
          m_mode = mode;
          m_ps   = 1'b1;
          for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i*DW +: DW]);
        end else begin
          m_p++;
        end
      end else begin
        m_q++;
      end
    end
    sb_q.push_back({m_pwm, m_ps});
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_pwm", 64'(pwm), 64'(e.pwm));
      chk("sb_ps", 64'(period_start), 64'(e.ps));
    end
  end

  // Wait (bounded) for a period_start pulse; leaves us on its falling edge.
  task automatic wait_ps(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_start !== 1'b1 && k < budget);
    chk("wait_ps", 64'(period_start), 64'd1);
  endtask

  // Measure one period starting at a period_start falling edge; optional mid-period write.
  task automatic measure(input int len, input int e0, input int e1, input int e2, input int e3,
                         input int chg_at, input logic [CH*DW-1:0] nduty, input logic nmode);
    int hi[CH];
    int ps_cnt;
    int ex[CH];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    ps_cnt = 0;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        duty = nduty;
        mode = nmode;
      end
      for (int c = 0; c < CH; c++) if (pwm[c] === 1'b1) hi[c]++;
      if (i < len && period_start === 1'b1) ps_cnt++;
    end
    chk("period_end", 64'(period_start), 64'd1);
    chk("period_mid_ps", 64'(ps_cnt), 64'd0);
    for (int c = 0; c < CH; c++) chk($sformatf("high_ch%0d", c), 64'(hi[c]), 64'(ex[c]));
  endtask

  initial begin
    int k;
    rst  = 1'b1;
    en   = 1'b0;
    dvsr = 32'd0;
    mode = 1'b0;
    duty = pk(0, 64, 128, 256);
    pol  = '0;

    repeat (3) @(negedge clk);
    chk("rst_pwm", 64'(pwm), 64'd0);
    chk("rst_ps", 64'(period_start), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_pwm", 64'(pwm), 64'd0);

    // Edge mode, dvsr=0: 256-clock periods.
    en = 1'b1;
    wait_ps(600);
    measure(256, 0, 64, 128, 256, -1, duty, mode);
    measure(256, 0, 64, 128, 256, -1, duty, mode);

    // Prescaled edge mode: 1024-clock periods.
    dvsr = 32'd3;
    duty = pk(0, 128, 128, 256);
    wait_ps(3000);
    measure(1024, 0, 512, 512, 1024, -1, duty, mode);

    // Center mode: 512-clock periods, high time 2*duty.
    dvsr = 32'd0;
    mode = 1'b1;
    duty = pk(0, 64, 128, 256);
    wait_ps(3000);
    measure(512, 0, 128, 256, 512, -1, duty, mode);

    // Shadowed duty and mode updates.
    mode = 1'b0;
    wait_ps(1200);
    measure(256, 0, 64, 128, 256, 40, pk(0, 64, 192, 256), 1'b0);
    measure(256, 0, 64, 192, 256, 100, duty, 1'b1);
    measure(512, 0, 128, 384, 512, -1, duty, mode);

    // Polarity, then disable.
    mode = 1'b0;
    pol  = 4'b0010;
    duty = pk(0, 64, 128, 256);
    wait_ps(1200);
    measure(256, 0, 192, 128, 256, -1, duty, mode);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_pwm", 64'(pwm), 64'h2);
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (period_start !== 1'b0) k++;
    end
    chk("dis_ps_quiet", 64'(k), 64'd0);
    chk("dis_pwm_hold", 64'(pwm), 64'h2);

    // Reset mid-period at cnt=100.
    pol = '0;
    en  = 1'b1;
    wait_ps(600);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pwm", 64'(pwm), 64'd0);
    chk("midrst_ps", 64'(period_start), 64'd0);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_start !== 1'b1 && k < 1000);
    chk("post_rst_len", 64'(k), 64'd256);
    measure(256, 0, 64, 128, 256, -1, duty, mode);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_mc.md
Name: pwm_mc

Overview:
Multi-channel PWM generator. It is the parametrised successor of the single-channel pwm: one shared prescaler and period counter drive CH comparators. Features over the single-channel block:
- edge-aligned or center-aligned counting
- glitch-free duty and mode updates, applied only at period boundaries
- per-channel output polarity
- a period-start strobe

It sits between control registers (duty/mode/polarity) and the output pins for LED dimming and motor drive.

Parameters:
n, 8, counter resolution in bits; one period holds 2^n counts
CH, 4, number of PWM channels (1..16)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  run enable; 0 holds the counters at 0 and outputs inactive
dvsr  input  32  prescaler divisor; one count tick every dvsr+1 clocks
mode  input  1  0 = edge-aligned, 1 = center-aligned
duty  input  CH*(n+1)  packed per-channel duty; channel i at [i*(n+1) +: n+1], range 0..2^n
pol  input  CH  per-channel polarity; 1 inverts the channel output
pwm  output  CH  PWM outputs, registered
period_start  output  1  one-clock pulse when a new period begins

Behaviour:
Reset (rst=1 at a clk edge):
- prescaler q=0, cnt=0, dir=up
- mode_act=0, all duty_act=0
- pwm=0, period_start=0
- rst overrides en; a reset mid-period aborts the period with no partial pulse afterwards.

Prescaler:
- 32-bit q counts 0..dvsr; tick=1 when en=1 and q==dvsr, and q returns to 0 on that clock.
- dvsr=0 gives a tick every clock.
- A dvsr change takes effect on the next compare; if q>dvsr, q keeps counting and wraps through 2^32-1 (no special handling).

Edge mode (mode_act=0):
- On tick, cnt increments modulo 2^n.
- Boundary = tick with cnt==2^n-1.
- Period = 2^n ticks.

Center mode (mode_act=1):
- Up phase: on tick, cnt increments 0..2^n-1. A tick at 2^n-1 sets dir=down and cnt holds.
- Down phase: on tick, cnt decrements 2^n-1..0. A tick at 0 sets dir=up and cnt holds.
- Boundary = tick with cnt==0 and dir==down.
- Period = 2^(n+1) ticks.

At a boundary (same clock):
- duty_act <= duty for all channels; mode_act <= mode.
- period_start <= 1 for exactly one clock.
- If mode differs from mode_act: cnt <= 0, dir <= up.

When en=0:
- q=0, cnt=0, dir=up; no ticks, period_start=0.
- duty_act <= duty and mode_act <= mode every clock (transparent), so the first period after enabling uses current values.
- pwm[i] <= pol[i] (inactive level).

Compare and output:
- Raw comparison: raw_i = (cnt < duty_act[i]), an unsigned (n+1)-bit compare.
- With en=1: pwm[i] <= raw_i ^ pol[i].
- Latency: one clock from a cnt update to the pwm change.
- Edge mode: high time = duty ticks.
- Center mode: high time = 2*duty ticks, a single pulse centred on the cnt==0 bottom of the count.
- duty=0 gives constant inactive; duty=2^n gives constant active, no glitch at wrap. Duty values >2^n behave as 2^n.

Simultaneous events:
- A duty change coinciding with a boundary clock is captured.
- A change on any other clock is ignored until the next boundary.
- pol is not shadowed and takes effect on the next clock.

Test Plan:
1. n=8, CH=4, dvsr=0, mode=0, duty={0,64,128,256}, pol=0, en=1 after reset -> period 256 clk; highs 0/64/128/256 clk per period; ch3 constant 1, ch0 constant 0; period_start every 256 clk.
2. dvsr=3, mode=0, duty ch1=128 -> period 1024 clk, ch1 high 512 clk; period_start spacing 1024 clk.
3. dvsr=0, mode=1, duty ch1=64 -> period 512 clk, ch1 high 128 clk contiguous, centred on the cnt==0 bottom; period_start every 512 clk.
4. Edge mode, ch2 duty 128->192 written mid-period (cnt=40) -> current period keeps 128 high; the next period after period_start shows 192 high. Also toggle mode 0->1 mid-period -> switch occurs only at the boundary, cnt restarts at 0 going up.
5. pol=4'b0010 with duty ch1=64 -> ch1 low for 64, high for 192 clk per period; with en=0 -> ch1 held 1, others 0, period_start silent.
6. Assert rst for 1 clk at cnt=100 -> next clock pwm=0, period_start=0; cnt restarts from 0 and the first period after reset has full 256-clk length.
